// File: rtl/gelato_types.sv
// gelato_types
// Shared types for the gelato operand collector.
//   opc_state_t : collector FSM states (IDLE, READ, DISPATCH)
//   operand_t   : one full-warp operand vector (threads * lane width bits)
//   inst_t      : issued instruction (warp id, three source indices, three use flags)
//   count_used  : number of set bits in a 3-bit source-use mask
package gelato_types;

    localparam int GELATO_NUM_THREADS    = 32;
    localparam int GELATO_DATA_WIDTH     = 32;
    localparam int GELATO_WARP_ID_WIDTH  = 5;
    localparam int GELATO_REG_IDX_WIDTH  = 5;
    localparam int GELATO_OPERAND_WIDTH  = GELATO_NUM_THREADS * GELATO_DATA_WIDTH;
    localparam int OPC_NUM_SLOTS         = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ     = 2'd1,
        DISPATCH = 2'd2
    } opc_state_t;

    typedef logic [GELATO_OPERAND_WIDTH-1:0] operand_t;

    typedef struct packed {
        logic [GELATO_WARP_ID_WIDTH-1:0] warp;
        logic [GELATO_REG_IDX_WIDTH-1:0] rs1;
        logic [GELATO_REG_IDX_WIDTH-1:0] rs2;
        logic [GELATO_REG_IDX_WIDTH-1:0] rs3;
        logic                            use_rs1;
        logic                            use_rs2;
        logic                            use_rs3;
    } inst_t;

    // Population count of the use mask; at most 3, so 2 bits suffice.
    function automatic logic [1:0] count_used(input logic [2:0] mask);
        return 2'(mask[0]) + 2'(mask[1]) + 2'(mask[2]);
    endfunction

endpackage

// File: rtl/gelato_opc_slot_sel.sv
// gelato_opc_slot_sel
// Combinational selector: finds the n-th used source slot (0 = rs1, 1 = rs2,
// 2 = rs3) in a use mask. Used by both the request and the response paths so
// that requests and captured data walk the slots in the same order.
//   used_mask_i : bit s set when slot s is used (bit0 = rs1)
//   ordinal_i   : which used slot to find (0 = first used slot)
//   slot_o      : slot index of that used slot (0 when not found)
//   valid_o     : high when the mask holds more than ordinal_i used slots
module gelato_opc_slot_sel
    import gelato_types::*;
(
    input  logic [2:0] used_mask_i,
    input  logic [1:0] ordinal_i,
    output logic [1:0] slot_o,
    output logic       valid_o
);

    logic [1:0] seen;

    // Walk slots in rs1, rs2, rs3 order counting used ones; the first slot
    // whose running count equals the ordinal is the answer.
    always_comb begin
        slot_o  = '0;
        valid_o = 1'b0;
        seen    = '0;
        for (int i = 0; i < OPC_NUM_SLOTS; i++) begin
            if (used_mask_i[i]) begin
                if (!valid_o && (seen == ordinal_i)) begin
                    slot_o  = 2'(i);
                    valid_o = 1'b1;
                end
                seen = seen + 2'd1;
            end
        end
    end

endmodule

// File: rtl/gelato_operand_collector.sv
// gelato_operand_collector
// Single-entry operand collector. Accepts one instruction from the warp
// scheduler, reads its used source registers from the register file (in
// rs1, rs2, rs3 order, in-order responses), then offers the instruction and
// its three operand vectors to execution. Unused operands are all-zero.
//   clk, rst                  : clock, synchronous active-high reset
//   inst_valid/inst_ready/inst: scheduler handshake (ready only in IDLE)
//   rf_req_*                  : register read request (valid/ready, warp, reg)
//   rf_rsp_valid/rf_rsp_data  : register read data, one vector per response
//   exec_valid/exec_ready     : execution handshake
//   exec_inst, exec_rs1..3    : latched instruction and collected operands
module gelato_operand_collector
    import gelato_types::*;
#(
    parameter int NUM_THREADS   = GELATO_NUM_THREADS,
    parameter int DATA_WIDTH    = GELATO_DATA_WIDTH,
    parameter int WARP_ID_WIDTH = GELATO_WARP_ID_WIDTH,
    parameter int REG_IDX_WIDTH = GELATO_REG_IDX_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              inst_valid,
    output logic                              inst_ready,
    input  inst_t                             inst,
    output logic                              rf_req_valid,
    input  logic                              rf_req_ready,
    output logic [WARP_ID_WIDTH-1:0]          rf_req_warp,
    output logic [REG_IDX_WIDTH-1:0]          rf_req_reg,
    input  logic                              rf_rsp_valid,
    input  logic [NUM_THREADS*DATA_WIDTH-1:0] rf_rsp_data,
    output logic                              exec_valid,
    input  logic                              exec_ready,
    output inst_t                             exec_inst,
    output logic [NUM_THREADS*DATA_WIDTH-1:0] exec_rs1,
    output logic [NUM_THREADS*DATA_WIDTH-1:0] exec_rs2,
    output logic [NUM_THREADS*DATA_WIDTH-1:0] exec_rs3
);

    opc_state_t state_q, state_d;
    inst_t      inst_q, inst_d;
    logic [1:0] req_cnt_q, req_cnt_d;
    logic [1:0] rsp_cnt_q, rsp_cnt_d;
    operand_t   op_q [3];
    operand_t   op_d [3];

    logic [2:0] used_mask;
    logic [1:0] num_used;
    logic [1:0] req_slot, rsp_slot;
    logic       req_slot_vld, rsp_slot_vld;
    logic [4:0] req_idx;
    logic       req_fire, rsp_take;

    assign used_mask = {inst_q.use_rs3, inst_q.use_rs2, inst_q.use_rs1};
    assign num_used  = count_used(used_mask);

    gelato_opc_slot_sel u_req_sel (
        .used_mask_i (used_mask),
        .ordinal_i   (req_cnt_q),
        .slot_o      (req_slot),
        .valid_o     (req_slot_vld)
    );

    gelato_opc_slot_sel u_rsp_sel (
        .used_mask_i (used_mask),
        .ordinal_i   (rsp_cnt_q),
        .slot_o      (rsp_slot),
        .valid_o     (rsp_slot_vld)
    );

    // A slot is still unrequested exactly when the request ordinal finds one.
    assign rf_req_valid = (state_q == READ) && req_slot_vld;
    assign req_fire     = rf_req_valid && rf_req_ready;
    // Only responses to already-issued requests are captured; anything else
    // (idle, after reset, nothing outstanding) is dropped.
    assign rsp_take     = (state_q == READ) && rf_rsp_valid && rsp_slot_vld
                          && (rsp_cnt_q != req_cnt_q);

    always_comb begin
        case (req_slot)
            2'd0:    req_idx = inst_q.rs1;
            2'd1:    req_idx = inst_q.rs2;
            default: req_idx = inst_q.rs3;
        endcase
    end

    assign rf_req_reg  = rf_req_valid ? req_idx     : '0;
    assign rf_req_warp = rf_req_valid ? inst_q.warp : '0;

    assign inst_ready = (state_q == IDLE);
    assign exec_valid = (state_q == DISPATCH);
    assign exec_inst  = inst_q;
    assign exec_rs1   = op_q[0];
    assign exec_rs2   = op_q[1];
    assign exec_rs3   = op_q[2];

    // Next-state logic. Request and response counters advance independently,
    // so a request and a response in the same cycle both count on that edge.
    // The last captured response moves the collector to DISPATCH.
    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        req_cnt_d = req_cnt_q;
        rsp_cnt_d = rsp_cnt_q;
        op_d      = op_q;
        case (state_q)
            IDLE: begin
                if (inst_valid) begin
                    inst_d    = inst;
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                    for (int i = 0; i < OPC_NUM_SLOTS; i++) begin
                        op_d[i] = '0;
                    end
                    state_d = (inst.use_rs1 || inst.use_rs2 || inst.use_rs3) ? READ : DISPATCH;
                end
            end
            READ: begin
                if (req_fire) begin
                    req_cnt_d = req_cnt_q + 2'd1;
                end
                if (rsp_take) begin
                    case (rsp_slot)
                        2'd0:    op_d[0] = rf_rsp_data;
                        2'd1:    op_d[1] = rf_rsp_data;
                        default: op_d[2] = rf_rsp_data;
                    endcase
                    rsp_cnt_d = rsp_cnt_q + 2'd1;
                    if ((rsp_cnt_q + 2'd1) == num_used) begin
                        state_d = DISPATCH;
                    end
                end
            end
            DISPATCH: begin
                if (exec_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            inst_q    <= '0;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
            for (int i = 0; i < OPC_NUM_SLOTS; i++) begin
                op_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            for (int i = 0; i < OPC_NUM_SLOTS; i++) begin
                op_q[i] <= op_d[i];
            end
        end
    end

endmodule

// File: tb/tb_gelato_operand_collector.sv
// tb_gelato_operand_collector
// Bench for the operand collector. The bench plays scheduler, register file
// and execution unit. Its reference model is transaction level: an issued
// instruction expects one read per used source in rs1, rs2, rs3 order, and
// each operand it later presents must equal the data returned for that
// source's read (zero when unused).
module tb_gelato_operand_collector;
    import gelato_types::*;

    localparam int OPW = GELATO_OPERAND_WIDTH;

    logic           clk = 1'b0;
    logic           rst;
    logic           inst_valid;
    logic           inst_ready;
    inst_t          instIn;
    logic           rf_req_valid;
    logic           rf_req_ready;
    logic [4:0]     rf_req_warp;
    logic [4:0]     rf_req_reg;
    logic           rf_rsp_valid;
    logic [OPW-1:0] rf_rsp_data;
    logic           exec_valid;
    logic           exec_ready;
    inst_t          exec_inst;
    logic [OPW-1:0] exec_rs1, exec_rs2, exec_rs3;

    always #5 clk = ~clk;

    gelato_operand_collector dut (
        .clk          (clk),
        .rst          (rst),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst         (instIn),
        .rf_req_valid (rf_req_valid),
        .rf_req_ready (rf_req_ready),
        .rf_req_warp  (rf_req_warp),
        .rf_req_reg   (rf_req_reg),
        .rf_rsp_valid (rf_rsp_valid),
        .rf_rsp_data  (rf_rsp_data),
        .exec_valid   (exec_valid),
        .exec_ready   (exec_ready),
        .exec_inst    (exec_inst),
        .exec_rs1     (exec_rs1),
        .exec_rs2     (exec_rs2),
        .exec_rs3     (exec_rs3)
    );

    typedef struct {
        int             due;
        int             slot;
        logic [OPW-1:0] data;
    } pend_t;

    int             nCompared = 0;
    int             nMismatched = 0;
    pend_t          pendQ[$];
    logic [OPW-1:0] lastOp [3];
    inst_t          lastInst;

    // Every comparison goes through here; wide values show their low 128 bits.
    task automatic checkOutput(input string tag, input logic [OPW-1:0] got, input logic [OPW-1:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got[127:0]=%h expected[127:0]=%h", tag, got[127:0], exp[127:0]);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 ns after the rising edge.
    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OPW-1:0] randOperand();
        logic [OPW-1:0] v;
        for (int i = 0; i < OPW / 32; i++) begin
            v[i*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    function automatic inst_t mkInst(input logic [4:0] w, input logic [4:0] r1, input logic [4:0] r2,
                                     input logic [4:0] r3, input logic u1, input logic u2, input logic u3);
        inst_t t;
        t.warp = w;  t.rs1 = r1;  t.rs2 = r2;  t.rs3 = r3;
        t.use_rs1 = u1;  t.use_rs2 = u2;  t.use_rs3 = u3;
        return t;
    endfunction

    // Issue one instruction and carry it to dispatch. Cycle 0 is the accept
    // cycle. rdyLo..rdyHi: cycles with rf_req_ready low (unless randRdy).
    // execHold: cycles exec_ready stays low once exec_valid rises.
    // expExec >= 0: required first exec_valid cycle. rstAt >= 0: cycle in
    // which rst is pulsed instead of completing.
    task automatic runInst(input inst_t in, input int lat, input int rdyLo, input int rdyHi,
                           input bit randRdy, input int execHold, input int expExec, input int rstAt);
        logic [4:0]     expReg[$];
        int             expSlot[$];
        logic [OPW-1:0] expOp [3];
        logic [4:0]     idx [3];
        bit             useF [3];
        logic [31:0]    r;
        int             cyc, execSeen, pendCur;
        bit             done;
        pend_t          p;

        useF = '{in.use_rs1, in.use_rs2, in.use_rs3};
        idx  = '{in.rs1, in.rs2, in.rs3};
        for (int s = 0; s < 3; s++) begin
            expOp[s] = '0;
            if (useF[s]) begin
                expReg.push_back(idx[s]);
                expSlot.push_back(s);
            end
        end

        checkOutput("accept_ready", inst_ready, 1'b1);
        instIn     = in;
        inst_valid = 1'b1;
        cyc        = 0;
        execSeen   = -1;
        done       = 1'b0;

        while (!done && cyc < 300) begin
            if (cyc > 0) begin
                r          = $urandom;
                inst_valid = 1'($urandom_range(0, 1));
                instIn     = r[22:0];
                checkOutput("busy_inst_ready", inst_ready, 1'b0);
            end
            if (randRdy) rf_req_ready = 1'($urandom_range(0, 1));
            else         rf_req_ready = !(cyc >= rdyLo && cyc <= rdyHi);

            rf_rsp_valid = 1'b0;
            rf_rsp_data  = randOperand();
            if (pendQ.size() > 0 && pendQ[0].due <= cyc) begin
                p            = pendQ.pop_front();
                rf_rsp_valid = 1'b1;
                rf_rsp_data  = p.data;
                if (p.slot >= 0) expOp[p.slot] = p.data;
            end

            if (rf_req_valid) begin
                if (expReg.size() == 0) begin
                    checkOutput("extra_request", rf_req_valid, 1'b0);
                end else begin
                    checkOutput("req_reg", rf_req_reg, expReg[0]);
                    checkOutput("req_warp", rf_req_warp, in.warp);
                    if (rf_req_ready) begin
                        void'(expReg.pop_front());
                        p.slot = expSlot.pop_front();
                        p.data = randOperand();
                        p.due  = cyc + lat;
                        pendQ.push_back(p);
                    end
                end
            end

            if (exec_valid) begin
                if (execSeen < 0) begin
                    execSeen = cyc;
                    if (expExec >= 0) checkOutput("exec_latency", cyc, expExec);
                    pendCur = 0;
                    foreach (pendQ[i]) if (pendQ[i].slot >= 0) pendCur++;
                    checkOutput("exec_after_all_rsp", pendCur + expReg.size(), 0);
                end
                checkOutput("exec_inst", exec_inst, in);
                checkOutput("exec_rs1", exec_rs1, expOp[0]);
                checkOutput("exec_rs2", exec_rs2, expOp[1]);
                checkOutput("exec_rs3", exec_rs3, expOp[2]);
                exec_ready = ((cyc - execSeen) >= execHold);
                if (exec_ready) done = 1'b1;
            end else begin
                exec_ready = 1'($urandom_range(0, 1));
            end

            if (cyc == rstAt) begin
                rst = 1'b1;
                waitCycle();
                cyc++;
                rst        = 1'b0;
                inst_valid = 1'b0;
                exec_ready = 1'b0;
                foreach (pendQ[i]) pendQ[i].slot = -1;
                checkOutput("rst_inst_ready", inst_ready, 1'b1);
                checkOutput("rst_req_valid", rf_req_valid, 1'b0);
                checkOutput("rst_exec_valid", exec_valid, 1'b0);
                checkOutput("rst_exec_inst", exec_inst, '0);
                checkOutput("rst_rs1", exec_rs1, '0);
                checkOutput("rst_rs2", exec_rs2, '0);
                checkOutput("rst_rs3", exec_rs3, '0);
                for (int k = 0; k < 10 && pendQ.size() > 0; k++) begin
                    rf_rsp_valid = 1'b0;
                    if (pendQ[0].due <= cyc) begin
                        p            = pendQ.pop_front();
                        rf_rsp_valid = 1'b1;
                        rf_rsp_data  = p.data;
                    end
                    waitCycle();
                    cyc++;
                    checkOutput("late_rsp_ops_zero", exec_rs1 | exec_rs2 | exec_rs3, '0);
                    checkOutput("late_rsp_idle", inst_ready, 1'b1);
                end
                rf_rsp_valid = 1'b0;
                lastInst     = '0;
                for (int s = 0; s < 3; s++) lastOp[s] = '0;
                return;
            end

            waitCycle();
            cyc++;
        end

        if (!done) checkOutput("dispatch_timeout", done, 1'b1);
        inst_valid   = 1'b0;
        rf_rsp_valid = 1'b0;
        exec_ready   = 1'b0;
        lastInst     = in;
        for (int s = 0; s < 3; s++) lastOp[s] = expOp[s];
    endtask

    // Responses with nothing outstanding while idle must change nothing.
    task automatic spuriousIdle(input int n);
        inst_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            rf_rsp_valid = 1'b1;
            rf_rsp_data  = '1;
            waitCycle();
            checkOutput("spur_inst_ready", inst_ready, 1'b1);
            checkOutput("spur_req_valid", rf_req_valid, 1'b0);
            checkOutput("spur_exec_valid", exec_valid, 1'b0);
            checkOutput("spur_exec_inst", exec_inst, lastInst);
            checkOutput("spur_rs1", exec_rs1, lastOp[0]);
            checkOutput("spur_rs2", exec_rs2, lastOp[1]);
            checkOutput("spur_rs3", exec_rs3, lastOp[2]);
        end
        rf_rsp_valid = 1'b0;
    endtask

    task automatic applyStimulus();
        logic [31:0] r;
        // Two used sources, RF always ready, 1-cycle latency.
        runInst(mkInst(5'd4, 5'd3, 5'd7, 5'd5, 1'b1, 1'b1, 1'b0), 1, -1, -1, 1'b0, 0, 4, -1);
        spuriousIdle(3);
        // No sources used.
        runInst(mkInst(5'd9, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0), 1, -1, -1, 1'b0, 0, 1, -1);
        // Three sources, request port stalled in cycles 1-3.
        runInst(mkInst(5'd17, 5'd10, 5'd20, 5'd30, 1'b1, 1'b1, 1'b1), 1, 1, 3, 1'b0, 0, 8, -1);
        // Execution holds off for 5 cycles; 2-cycle RF latency.
        runInst(mkInst(5'd2, 5'd11, 5'd12, 5'd13, 1'b1, 1'b1, 1'b1), 2, -1, -1, 1'b0, 5, 6, -1);
        // Reset in READ after the first of three responses.
        runInst(mkInst(5'd31, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1), 1, -1, -1, 1'b0, 0, -1, 3);
        spuriousIdle(2);
        // Clean collection after the reset; rs2 and rs3 only, 3-cycle latency.
        runInst(mkInst(5'd6, 5'd21, 5'd22, 5'd23, 1'b0, 1'b1, 1'b1), 3, -1, -1, 1'b0, 0, 6, -1);
        // Random instructions, random ready, latencies and execution stalls.
        for (int t = 0; t < 40; t++) begin
            r = $urandom;
            runInst(r[22:0], $urandom_range(1, 4), -1, -1, 1'b1, $urandom_range(0, 3), -1, -1);
        end
    endtask

    initial begin
        rst          = 1'b1;
        inst_valid   = 1'b0;
        instIn       = '0;
        rf_req_ready = 1'b0;
        rf_rsp_valid = 1'b0;
        rf_rsp_data  = '0;
        exec_ready   = 1'b0;
        lastInst     = '0;
        for (int s = 0; s < 3; s++) lastOp[s] = '0;
        repeat (3) waitCycle();
        rst = 1'b0;
        checkOutput("reset_inst_ready", inst_ready, 1'b1);
        checkOutput("reset_req_valid", rf_req_valid, 1'b0);
        checkOutput("reset_exec_valid", exec_valid, 1'b0);
        checkOutput("reset_req_warp", rf_req_warp, '0);
        checkOutput("reset_req_reg", rf_req_reg, '0);
        checkOutput("reset_exec_inst", exec_inst, '0);
        checkOutput("reset_rs1", exec_rs1, '0);
        checkOutput("reset_rs2", exec_rs2, '0);
        checkOutput("reset_rs3", exec_rs3, '0);
        applyStimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/gelato_operand_collector.md
# gelato_operand_collector

Single-entry operand collector between the warp scheduler and the execution units. Accepts one issued instruction from the warp scheduler, fetches its up-to-three source operands (full-warp vectors) from the register file over a request/response port, then presents the instruction plus collected operands to execution with a valid/ready handshake. It holds one instruction at a time; a new instruction is accepted only after the previous one has been dispatched.

## Interface
Parameters:
- NUM_THREADS, 32, threads per warp (lanes per operand vector)
- DATA_WIDTH, 32, bits per lane
- WARP_ID_WIDTH, 5, width of warp id in requests
- REG_IDX_WIDTH, 5, width of architectural register index

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- inst_valid  in  1  scheduler offers an instruction
- inst_ready  out  1  collector can accept (high only in IDLE)
- inst  in  inst_t  issued instruction (warp id, rs1/rs2/rs3 indices, use_rs1/2/3 flags)
- rf_req_valid  out  1  register read request valid
- rf_req_ready  in  1  register file accepts request this cycle
- rf_req_warp  out  WARP_ID_WIDTH  warp of requested register
- rf_req_reg  out  REG_IDX_WIDTH  register index
- rf_rsp_valid  in  1  read data returning (in request order)
- rf_rsp_data  in  NUM_THREADS*DATA_WIDTH  read data vector
- exec_valid  out  1  collected instruction ready for execution
- exec_ready  in  1  execution accepts
- exec_inst  out  inst_t  latched instruction
- exec_rs1, exec_rs2, exec_rs3  out  NUM_THREADS*DATA_WIDTH each  operand vectors

## Operation
- States: IDLE, READ, DISPATCH.
- IDLE: inst_ready=1. On inst_valid: latch inst; zero all three operand registers; build used-slot list from use flags in order rs1, rs2, rs3; reset request/response counters. If no slot used -> DISPATCH, else -> READ.
- READ: rf_req_valid=1 while requests remain; rf_req_reg = index of next unrequested used slot, rf_req_warp = latched warp id. Request counter advances only on rf_req_valid && rf_req_ready; while ready low, request held stable.
- Responses: each rf_rsp_valid while responses outstanding writes rf_rsp_data into the operand register of the next used slot in order (response counter). rf_rsp_valid with zero outstanding is ignored.
- READ -> DISPATCH when all requests issued and all responses captured (last response edge).
- DISPATCH: exec_valid=1, exec_inst/exec_rs* stable. On exec_ready -> IDLE. New instruction not accepted in dispatch cycle.
- Unused slots output all-zero.
- Reset (any state, mid-read included): state IDLE, counters 0, operand and exec_inst registers 0; any response arriving afterward ignored.

## Timing
- Reset values: inst_ready=1 (IDLE), rf_req_valid=0, exec_valid=0, rf_req_warp/rf_req_reg=0, exec_inst=0, exec_rs1/2/3=0.
- inst_ready, rf_req_valid, exec_valid are decoded from registered state only; no combinational path from inst_valid or exec_ready to any output.
- Latency with rf_req_ready=1 and 1-cycle RF: accept in cycle 0; k used operands (k>=1) -> requests cycles 1..k, responses cycles 2..k+1, exec_valid first high cycle k+2. k=0 -> exec_valid cycle 1.
- Requests back-to-back, up to 3 outstanding; RF latency any >=1 cycle, in-order.
- Response in same cycle as a request: both counters update that edge.

## Structure
- gelato_types package gains: opc_state_t enum (IDLE, READ, DISPATCH), operand_t (NUM_THREADS*DATA_WIDTH vector), use_rs1/2/3 and rs1/2/3 fields in inst_t.
- One sub-module: gelato_opc_slot_sel, combinational: given 3-bit used mask and ordinal n, returns slot index of nth used slot and a valid bit; shared by request and response paths.

## Test plan
- inst uses rs1=3, rs2=7, rs3 unused, warp 4, RF always ready, 1-cycle latency -> requests (4,3) cycle 1, (4,7) cycle 2; exec_valid cycle 4; exec_rs3=0.
- inst with no use flags -> no rf_req_valid; exec_valid cycle 1, all operands 0.
- rf_req_ready low cycles 1-3 on a 3-operand inst -> first request held at rs1 unchanged; exec_valid 3 cycles later than nominal (cycle 8).
- exec_ready low 5 cycles in DISPATCH -> exec_valid and data stable; inst_ready stays 0; inst_valid ignored until return to IDLE.
- rst asserted in READ after 1 of 3 responses -> next cycle IDLE, inst_ready=1, operands 0; late responses leave operands 0; next inst collects cleanly.
- Spurious rf_rsp_valid in IDLE with data 0xFFFF... -> no state or operand change.
